anim_sequencer: RTL

ANIM_SEQUENCER -- requirements
Module: anim_sequencer

---
 rtl/anim_pkg.sv | 20 ++
 rtl/anim_addr_gen.sv | 88 ++++++++
 rtl/anim_sequencer.sv | 151 +++++++++++++++
 3 files changed

// File: rtl/anim_pkg.sv
// ---------------------------------------------------------------------------
// anim_pkg
// Shared definitions for the LED animation sequencer: default geometry of the
// frame memory and the sequencer state encoding.
// Optional build macro used by the design: ANIM_PINGPONG_EN (bounce playback).
// ---------------------------------------------------------------------------
package anim_pkg;

   localparam int FRAME_W_DEF   = 10;
   localparam int FRAMES_DEF    = 20;
   localparam int NUM_BANKS_DEF = 2;

   typedef enum logic [1:0] {
      LOAD    = 2'd0,
      WAIT    = 2'd1,
      PLAYING = 2'd2,
      PAUSED  = 2'd3
   } state_t;

endpackage

// File: rtl/anim_addr_gen.sv
// ---------------------------------------------------------------------------
// anim_addr_gen
// Next-value logic for the frame index, the bank number and (in bounce
// builds) the playback direction, plus the matching frame memory address.
// Purely combinational; the registers live in anim_sequencer.
// Build macro: ANIM_PINGPONG_EN selects bounce playback 0..FRAMES-1..0,
// otherwise the index wraps FRAMES-1 -> 0 and no direction exists.
//
// Ports
//   idx, bank           current index / bank
//   dir_down            current direction (ANIM_PINGPONG_EN only)
//   bank_adv            advance bank, index to 0 (highest priority)
//   hold                force index to 0
//   adv                 advance index by one frame
//   idx_nxt, bank_nxt   next index / bank
//   dir_down_nxt        next direction (ANIM_PINGPONG_EN only)
//   addr_nxt            bank_nxt*FRAMES + idx_nxt
// ---------------------------------------------------------------------------
module anim_addr_gen
   import anim_pkg::*;
#(
   parameter int FRAMES    = FRAMES_DEF,
   parameter int NUM_BANKS = NUM_BANKS_DEF,
   parameter int ADDR_W    = 6,
   parameter int IDX_W     = $clog2(FRAMES),
   parameter int BANK_W    = (NUM_BANKS > 1) ? $clog2(NUM_BANKS) : 1
) (
   input  logic [IDX_W-1:0]  idx,
   input  logic [BANK_W-1:0] bank,
`ifdef ANIM_PINGPONG_EN
   input  logic              dir_down,
   output logic              dir_down_nxt,
`endif
   input  logic              bank_adv,
   input  logic              hold,
   input  logic              adv,
   output logic [IDX_W-1:0]  idx_nxt,
   output logic [BANK_W-1:0] bank_nxt,
   output logic [ADDR_W-1:0] addr_nxt
);

   localparam logic [IDX_W-1:0]  IDX_LAST  = IDX_W'(FRAMES - 1);
   localparam logic [BANK_W-1:0] BANK_LAST = BANK_W'(NUM_BANKS - 1);

   always_comb begin
      idx_nxt  = idx;
      bank_nxt = bank;
`ifdef ANIM_PINGPONG_EN
      dir_down_nxt = dir_down;
`endif
      if (bank_adv) begin
         bank_nxt = (bank == BANK_LAST) ? '0 : bank + BANK_W'(1);
         idx_nxt  = '0;
`ifdef ANIM_PINGPONG_EN
         dir_down_nxt = 1'b0;
`endif
      end else if (hold) begin
         idx_nxt = '0;
`ifdef ANIM_PINGPONG_EN
         dir_down_nxt = 1'b0;
`endif
      end else if (adv) begin
`ifdef ANIM_PINGPONG_EN
         // turn around at either end without repeating the end frame
         if (!dir_down) begin
            if (idx == IDX_LAST) begin
               idx_nxt      = IDX_LAST - IDX_W'(1);
               dir_down_nxt = 1'b1;
            end else begin
               idx_nxt = idx + IDX_W'(1);
            end
         end else begin
            if (idx == '0) begin
               idx_nxt      = IDX_W'(1);
               dir_down_nxt = 1'b0;
            end else begin
               idx_nxt = idx - IDX_W'(1);
            end
         end
`else
         idx_nxt = (idx == IDX_LAST) ? '0 : idx + IDX_W'(1);
`endif
      end
   end

   assign addr_nxt = ADDR_W'(bank_nxt) * ADDR_W'(FRAMES) + ADDR_W'(idx_nxt);

endmodule

// File: rtl/anim_sequencer.sv
// ---------------------------------------------------------------------------
// anim_sequencer
// Steps an LED pattern through a bank of frames held in an external memory
// with one cycle read latency. Supports play/pause, single step, bank
// selection and a hold-to-first-frame level.
// Build macro: ANIM_PINGPONG_EN enables bounce playback (see anim_addr_gen).
//
// Ports
//   CLK, RSTN        system clock, async active-low reset
//   tick_i           frame advance strobe while playing
//   play_i           toggle play/pause
//   step_i           single frame advance while paused
//   bank_i           next bank, fetches its frame 0
//   hold_i           level, keeps the index at 0
//   mem_addr_o/rd_o  frame memory read request
//   mem_data_i       read data, valid the cycle after mem_rd_o
//   frame_o          displayed pattern, frame_valid_o pulses on update
//   bank_o           current bank, playing_o current run flag
//
// state   | meaning
// --------+----------------------------------------------------------------
// LOAD    | read request out (after reset: first cycle primes mem_rd_o)
// WAIT    | memory data arriving, captured into frame_o at end of cycle
// PLAYING | idle, tick_i advances
// PAUSED  | idle, step_i advances
// ---------------------------------------------------------------------------
module anim_sequencer
   import anim_pkg::*;
#(
   parameter int FRAME_W   = FRAME_W_DEF,
   parameter int FRAMES    = FRAMES_DEF,
   parameter int NUM_BANKS = NUM_BANKS_DEF,
   parameter int ADDR_W    = 6
) (
   input  logic                CLK,
   input  logic                RSTN,
   input  logic                tick_i,
   input  logic                play_i,
   input  logic                step_i,
   input  logic                bank_i,
   input  logic                hold_i,
   output logic [ADDR_W-1:0]   mem_addr_o,
   output logic                mem_rd_o,
   input  logic [FRAME_W-1:0]  mem_data_i,
   output logic [FRAME_W-1:0]  frame_o,
   output logic                frame_valid_o,
   output logic [((NUM_BANKS > 1) ? $clog2(NUM_BANKS) : 1)-1:0] bank_o,
   output logic                playing_o
);

   localparam int IDX_W  = $clog2(FRAMES);
   localparam int BANK_W = (NUM_BANKS > 1) ? $clog2(NUM_BANKS) : 1;

   state_t             state;
   logic [IDX_W-1:0]   idx;
   logic [IDX_W-1:0]   idx_nxt;
   logic [BANK_W-1:0]  bank_nxt;
   logic [ADDR_W-1:0]  addr_nxt;
   logic               bank_pend;
   logic               idle;
   logic               do_bank;
   logic               do_hold;
   logic               do_adv;
   logic               run_nxt;
`ifdef ANIM_PINGPONG_EN
   logic               dir_down;
   logic               dir_down_nxt;
`endif

   assign idle    = (state == PLAYING) || (state == PAUSED);
   assign do_bank = idle && (bank_i || bank_pend);
   assign do_hold = idle && hold_i;
   assign do_adv  = ((state == PLAYING) && tick_i) || ((state == PAUSED) && step_i);
   assign run_nxt = playing_o ^ play_i;

   anim_addr_gen #(
      .FRAMES    (FRAMES),
      .NUM_BANKS (NUM_BANKS),
      .ADDR_W    (ADDR_W),
      .IDX_W     (IDX_W),
      .BANK_W    (BANK_W)
   ) u_addr_gen (
      .idx          (idx),
      .bank         (bank_o),
`ifdef ANIM_PINGPONG_EN
      .dir_down     (dir_down),
      .dir_down_nxt (dir_down_nxt),
`endif
      .bank_adv     (do_bank),
      .hold         (do_hold),
      .adv          (do_adv),
      .idx_nxt      (idx_nxt),
      .bank_nxt     (bank_nxt),
      .addr_nxt     (addr_nxt)
   );

   // Index/bank/address only move in idle cycles (all controls are gated by
   // idle), so mem_addr_o stays put through LOAD and WAIT.
   always_ff @(posedge CLK or negedge RSTN) begin
      if (!RSTN) begin
         state         <= LOAD;
         idx           <= '0;
         bank_o        <= '0;
         mem_addr_o    <= '0;
         mem_rd_o      <= 1'b0;
         frame_o       <= '0;
         frame_valid_o <= 1'b0;
         playing_o     <= 1'b1;
         bank_pend     <= 1'b0;
`ifdef ANIM_PINGPONG_EN
         dir_down      <= 1'b0;
`endif
      end else begin
         idx           <= idx_nxt;
         bank_o        <= bank_nxt;
         mem_addr_o    <= addr_nxt;
`ifdef ANIM_PINGPONG_EN
         dir_down      <= dir_down_nxt;
`endif
         playing_o     <= run_nxt;
         frame_valid_o <= 1'b0;
         unique case (state)
            LOAD: begin
               if (!mem_rd_o) begin
                  mem_rd_o <= 1'b1;
               end else begin
                  mem_rd_o <= 1'b0;
                  state    <= WAIT;
               end
               if (bank_i) bank_pend <= 1'b1;
            end
            WAIT: begin
               frame_o       <= mem_data_i;
               frame_valid_o <= 1'b1;
               state         <= run_nxt ? PLAYING : PAUSED;
               if (bank_i) bank_pend <= 1'b1;
            end
            default: begin
               bank_pend <= 1'b0;
               if (do_bank || do_adv) begin
                  mem_rd_o <= 1'b1;
                  state    <= LOAD;
               end else begin
                  state    <= run_nxt ? PLAYING : PAUSED;
               end
            end
         endcase
      end
   end

endmodule
